// File: rtl/wave_switch_ctrl.sv
// wave_switch_ctrl: click-free waveform select sequencer.
// Fades the output gain to zero, waits for a phase wrap (or timeout),
// switches wave_select, then fades the gain back to full scale.
module wave_switch_ctrl #(
  parameter int GAIN_W  = 8,
  parameter int STEP    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              phase_wrap,
  input  logic              req_valid,
  input  logic [2:0]        req_sel,
  output logic              req_ready,
  output logic [2:0]        wave_select,
  output logic [GAIN_W-1:0] gain,
  output logic              busy,
  output logic              err_invalid
);

  localparam logic [GAIN_W-1:0] FULL   = '1;
  localparam logic [GAIN_W:0]   STEP_W = (GAIN_W+1)'(STEP);
  localparam logic [16:0]       TMO    = 17'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FADE_OUT, WAIT_WRAP, FADE_IN} state_t;

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [2:0]  pend_sel;

  // Widened sums so neither the fade-in add nor the counter increment wraps.
  logic [GAIN_W:0] gain_up;
  logic [16:0]     cnt_nxt;
  assign gain_up = {1'b0, gain} + STEP_W;
  assign cnt_nxt = {1'b0, tmo_cnt} + 17'd1;

  // Handshake and status are pure decodes of the state.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Sequencer: all registered outputs and state update here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wave_select <= 3'd0;
      gain        <= FULL;
      err_invalid <= 1'b0;
      tmo_cnt     <= 16'd0;
      pend_sel    <= 3'd0;
    end else begin
      err_invalid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_sel > 3'd5) begin
              err_invalid <= 1'b1;
            end else if (req_sel != wave_select) begin
              pend_sel <= req_sel;
              state    <= FADE_OUT;
            end
          end
        end
        FADE_OUT: begin
          // phase_wrap is deliberately ignored here, even on the last step.
          if (sample_tick) begin
            if ({1'b0, gain} > STEP_W) begin
              gain <= gain - STEP_W[GAIN_W-1:0];
            end else begin
              gain    <= '0;
              tmo_cnt <= 16'd0;
              state   <= WAIT_WRAP;
            end
          end
        end
        WAIT_WRAP: begin
          // Wrap and timeout together still yield a single switch.
          if (phase_wrap || (sample_tick && cnt_nxt == TMO)) begin
            wave_select <= pend_sel;
            state       <= FADE_IN;
          end else if (sample_tick) begin
            tmo_cnt <= cnt_nxt[15:0];
          end
        end
        FADE_IN: begin
          if (sample_tick) begin
            if (gain_up >= {1'b0, FULL}) begin
              gain  <= FULL;
              state <= IDLE;
            end else begin
              gain <= gain_up[GAIN_W-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_switch_ctrl.sv
// Directed bench: DUT a uses default parameters, DUT b uses TIMEOUT=4.
module tb_wave_switch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_tick = 0, a_wrap = 0, a_valid = 0;
  logic [2:0] a_sel = 0;
  logic       a_rdy, a_busy, a_err;
  logic [2:0] a_ws;
  logic [7:0] a_gain;

  logic       b_tick = 0, b_wrap = 0, b_valid = 0;
  logic [2:0] b_sel = 0;
  logic       b_rdy, b_busy, b_err;
  logic [2:0] b_ws;
  logic [7:0] b_gain;

  int checks = 0;
  int errors = 0;

  wave_switch_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .sample_tick(a_tick), .phase_wrap(a_wrap),
    .req_valid(a_valid), .req_sel(a_sel), .req_ready(a_rdy),
    .wave_select(a_ws), .gain(a_gain), .busy(a_busy), .err_invalid(a_err)
  );

  wave_switch_ctrl #(.GAIN_W(8), .STEP(8), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .sample_tick(b_tick), .phase_wrap(b_wrap),
    .req_valid(b_valid), .req_sel(b_sel), .req_ready(b_rdy),
    .wave_select(b_ws), .gain(b_gain), .busy(b_busy), .err_invalid(b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp;

    // Reset with random inputs
    repeat (4) begin
      a_tick = 1'($urandom); a_wrap = 1'($urandom); a_valid = 1'($urandom); a_sel = 3'($urandom);
      b_tick = 1'($urandom); b_wrap = 1'($urandom); b_valid = 1'($urandom); b_sel = 3'($urandom);
      step();
    end
    check("rst_ws", a_ws, 0);
    check("rst_gain", a_gain, 255);
    check("rst_ready", a_rdy, 1);
    check("rst_busy", a_busy, 0);
    check("rst_err", a_err, 0);
    check("rst_b_gain", b_gain, 255);
    a_tick = 0; a_wrap = 0; a_valid = 0; a_sel = 0;
    b_tick = 0; b_wrap = 0; b_valid = 0; b_sel = 0;
    step();
    rst_n = 1'b1;
    step();

    // Normal switch 0->3 on DUT a, tick every 4 clocks
    a_valid = 1; a_sel = 3;
    step();
    a_valid = 0;
    check("acc_busy", a_busy, 1);
    check("acc_ready", a_rdy, 0);
    check("acc_gain", a_gain, 255);
    exp = 255;
    for (int k = 1; k <= 32; k++) begin
      a_tick = 1; step(); a_tick = 0;
      exp = (exp > 8) ? exp - 8 : 0;
      check("fade_out", a_gain, exp);
      repeat (3) step();
    end
    check("fo_7_then_0", a_gain, 0);
    for (int k = 0; k < 10; k++) begin
      a_tick = 1; step(); a_tick = 0;
      check("wait_ws", a_ws, 0);
      check("wait_gain", a_gain, 0);
      repeat (3) step();
    end
    a_wrap = 1; step(); a_wrap = 0;
    check("wrap_ws", a_ws, 3);
    check("wrap_gain", a_gain, 0);
    exp = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 20) begin a_valid = 1; a_sel = 1; end
      a_tick = 1; step(); a_tick = 0;
      exp = (exp + 8 > 255) ? 255 : exp + 8;
      check("fade_in", a_gain, exp);
      if (k < 32) begin
        check("fi_busy", a_busy, 1);
        repeat (3) step();
        check("bp_ws", a_ws, 3);
      end
    end
    // Back-pressured request is held; accepted on the next edge
    check("fi_ready", a_rdy, 1);
    check("bp_not_yet", a_ws, 3);
    step();
    a_valid = 0;
    check("bp_acc_busy", a_busy, 1);
    a_tick = 1;
    exp = 255;
    for (int k = 1; k <= 32; k++) begin
      step();
      exp = (exp > 8) ? exp - 8 : 0;
      check("bp_fade_out", a_gain, exp);
    end
    a_tick = 0;
    a_wrap = 1; step(); a_wrap = 0;
    check("bp_ws_1", a_ws, 1);
    a_tick = 1;
    repeat (32) step();
    a_tick = 0;
    check("bp_fi_gain", a_gain, 255);
    check("bp_fi_ready", a_rdy, 1);

    // Illegal and same-code requests on DUT a (wave_select=1)
    for (int c = 6; c <= 7; c++) begin
      a_valid = 1; a_sel = 3'(c);
      step();
      a_valid = 0;
      check("ill_err", a_err, 1);
      check("ill_busy", a_busy, 0);
      check("ill_ws", a_ws, 1);
      step();
      check("ill_err_off", a_err, 0);
      check("ill_busy2", a_busy, 0);
    end
    a_valid = 1; a_sel = 1;
    step();
    a_valid = 0;
    check("same_busy", a_busy, 0);
    check("same_err", a_err, 0);
    step();
    check("same_busy2", a_busy, 0);
    check("same_gain", a_gain, 255);

    // Timeout on DUT b; wrap on the last fade-out tick is ignored
    b_valid = 1; b_sel = 2;
    step();
    b_valid = 0;
    b_tick = 1;
    repeat (31) step();
    check("b_fo_7", b_gain, 7);
    b_wrap = 1; step(); b_wrap = 0;
    check("b_fo_0", b_gain, 0);
    check("b_wrap_ignored", b_ws, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("b_tmo_wait", b_ws, 0);
    end
    step();
    check("b_tmo_ws", b_ws, 2);
    check("b_tmo_gain", b_gain, 0);
    repeat (32) step();
    check("b_fi_gain", b_gain, 255);
    check("b_fi_ready", b_rdy, 1);

    // Wrap coincident with 4th tick: exactly one switch
    b_valid = 1; b_sel = 4;
    step();
    b_valid = 0;
    repeat (32) step();
    check("b2_fo_0", b_gain, 0);
    repeat (3) step();
    check("b2_wait_ws", b_ws, 2);
    b_wrap = 1; step(); b_wrap = 0;
    check("b2_ws", b_ws, 4);
    check("b2_busy", b_busy, 1);
    step();
    check("b2_one_switch_gain", b_gain, 8);
    repeat (31) step();
    check("b2_fi_gain", b_gain, 255);
    check("b2_idle", b_busy, 0);

    // Reset mid-WAIT_WRAP with pending select 5
    b_valid = 1; b_sel = 5;
    step();
    b_valid = 0;
    repeat (33) step();
    b_tick = 0;
    check("b3_wait_gain", b_gain, 0);
    check("b3_wait_busy", b_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("b3_rst_gain", b_gain, 255);
    check("b3_rst_ws", b_ws, 0);
    check("b3_rst_busy", b_busy, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_tick = 1; b_wrap = 1'(k & 1);
      step();
    end
    b_tick = 0; b_wrap = 0;
    check("b3_no_switch", b_ws, 0);
    check("b3_gain", b_gain, 255);
    check("b3_idle", b_rdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_switch_ctrl.md
# wave_switch_ctrl

Sequences changes of the waveform-select code that drives the DDS output mux so that switching waveforms never produces an audible click. A requested selection is accepted through a valid/ready handshake. The block then ramps an output gain word down to zero and waits for a phase-accumulator wrap before changing `wave_select`. It then ramps the gain back up to full scale. It sits between the control/register interface and the waveform mux plus output gain multiplier.

## Interface
Parameters:
- `GAIN_W`, 8, gain word width; full scale is `2^GAIN_W-1`.
- `STEP`, 8, gain change per `sample_tick` during fades; legal range 1..`2^GAIN_W-1`.
- `TIMEOUT`, 1024, number of `sample_tick`s to wait for `phase_wrap` before switching anyway; legal range 1..65535.

Ports:
- `clk`, in, 1, system clock; all state changes on its rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `sample_tick`, in, 1, one-cycle pulse per output sample; paces both fades and the timeout.
- `phase_wrap`, in, 1, one-cycle pulse when the phase accumulator wraps.
- `req_valid`, in, 1, a new selection request is present.
- `req_sel`, in, 3, requested select code; codes 0..5 are legal.
- `req_ready`, out, 1, block can accept a request; high only in IDLE.
- `wave_select`, out, 3, select code driven to the waveform mux.
- `gain`, out, `GAIN_W`, gain word driven to the output scaler.
- `busy`, out, 1, high in any state other than IDLE.
- `err_invalid`, out, 1, one-cycle pulse when an illegal code is presented and handshaken.

## Operation
- Reset, asynchronous: state IDLE, `wave_select`=0, `gain`=full scale, `err_invalid`=0, timeout counter=0, pending select=0. `req_ready`=1 and `busy`=0 follow from IDLE.
- `req_ready` and `busy` are decoded combinationally from state. All other outputs are registered.
- **IDLE:** a request is accepted on `req_valid && req_ready`.
  - `req_sel` > 5: `err_invalid` pulses for one cycle, the request is dropped and state stays IDLE.
  - `req_sel` == `wave_select`: the request is consumed as a no-op and state stays IDLE.
  - Otherwise: `req_sel` is latched as the pending select and the next state is FADE_OUT.
- **FADE_OUT:** on each `sample_tick`, `gain` <= (`gain` > `STEP`) ? `gain`-`STEP` : 0. Saturating; never wraps below 0.
  - The tick that makes `gain` 0 moves the state to WAIT_WRAP and clears the timeout counter.
- **WAIT_WRAP:** `gain` is held at 0. Each `sample_tick` increments the timeout counter.
  - Switch condition: `phase_wrap`=1, or a `sample_tick` that would bring the counter to `TIMEOUT`.
  - On the switch condition: `wave_select` <= pending select, next state FADE_IN.
  - `phase_wrap` and timeout in the same cycle produce exactly one switch.
- **FADE_IN:** on each `sample_tick`, `gain` <= min(`gain`+`STEP`, full scale), computed one bit wider so it cannot overflow.
  - The tick that makes `gain` full scale moves the state to IDLE.
- `phase_wrap` is ignored outside WAIT_WRAP. This includes a pulse in the same cycle that FADE_OUT reaches 0.
- `req_valid` is ignored while not in IDLE. The requester must hold the request until `req_ready`.
- Reset asserted mid-sequence aborts immediately to reset values. The pending select is discarded.

## Timing
- Request accepted at edge N: `busy`=1 and `req_ready`=0 from after edge N. The first gain step happens on the first `sample_tick` after edge N.
- `err_invalid` is high for exactly the cycle after the handshake edge.
- Fade length with default parameters: ceil(255/8) = 32 `sample_tick`s each way.
  - Fade-out sequence: 255, 247, …, 7, 0.
  - Fade-in sequence: 0, 8, …, 248, 255.
- `wave_select` changes only while `gain`=0, on the same edge that enters FADE_IN.
- `sample_tick` asserted continuously means one step per clock. This is legal and is the fastest case.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> `wave_select`=0, `gain`=255, `req_ready`=1, `busy`=0, `err_invalid`=0.
- Normal switch 0->3 with a tick every 4 clocks and `phase_wrap` 10 ticks after `gain`=0:
  - `gain` falls 255, 247, …, 7, 0 over 32 ticks.
  - `wave_select` becomes 3 on the wrap edge.
  - `gain` rises 0, 8, …, 248, 255 over 32 ticks, then `req_ready`=1.
- Timeout with `TIMEOUT`=4 and no `phase_wrap`: `wave_select` changes on the 4th tick after `gain`=0. Separately, `phase_wrap` coincident with the 4th tick -> exactly one switch.
- Illegal and same-code requests:
  - `req_sel`=6, and separately 7 -> `err_invalid` high one cycle, `wave_select` unchanged, `busy` never high.
  - `req_sel`=`wave_select` -> no fade, `busy`=0.
- Back-pressure: assert `req_valid` with `req_sel`=1 during FADE_IN -> no acceptance until IDLE; the request is then accepted and a new sequence starts.
- Reset mid-WAIT_WRAP with pending select 5 -> outputs at reset values immediately, `wave_select`=0, and no later switch to 5.
